mips_debug_ctrl: RTL and testbench
==================================

# mips_debug_ctrl

Debug/load controller that sequences the TP4 MIPS pipeline from a byte-serial host link. It assembles incoming bytes into 32-bit instructions and writes them into program memory. It then runs the pipeline either continuously or one cycle per host step command. After each step, and when HALT reaches writeback, it streams a state dump (cycle count, then selected debug words) back to the host. It sits between the UART receive/transmit FIFOs and the TP4 top level, replacing testbench-driven instruction loading and step flags.

## Interface
- PM_DEPTH, 64: program memory depth in words; PM_ADDR width = clog2(PM_DEPTH).
- DUMP_WORDS, 97: debug words per dump (PC + 32 regs + 32 data mem + 32 pipeline/latch words); DUMP_SEL width = clog2(DUMP_WORDS).
- HALT_WORD, 32'hFFFFFFFF: end-of-program marker instruction.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- RX_VALID  in  1  host byte available; consumed in the same cycle it is high.
- RX_DATA  in  8  host byte.
- TX_READY  in  1  transmitter can accept a byte.
- TX_VALID  out  1  TX_DATA valid.
- TX_DATA  out  8  dump byte.
- PM_WE  out  1  program memory write strobe.
- PM_ADDR  out  clog2(PM_DEPTH)  program memory write address.
- PM_WDATA  out  32  instruction word.
- CPU_EN  out  1  pipeline clock enable (replaces FLAG_STEP).
- CPU_RESET  out  1  synchronous pipeline reset pulse.
- HALT_WB  in  1  HALT instruction is in writeback this cycle.
- DUMP_SEL  out  clog2(DUMP_WORDS)  debug word index.
- DUMP_DATA  in  32  selected debug word, combinational from DUMP_SEL.

## Operation
- States: IDLE, LOAD, WAIT_CMD, RUN, STEP_WAIT, STEP, DUMP, DONE.
- IDLE: byte 0x4C ('L') -> LOAD with PM_ADDR=0 and byte counter=0. All other bytes are ignored.
- LOAD: bytes are assembled MSB first. On the 4th byte, PM_WE=1 for one cycle with the assembled word at PM_ADDR, then PM_ADDR increments. LOAD exits to WAIT_CMD after writing HALT_WORD (the marker itself is written) or after writing address PM_DEPTH-1, whichever comes first.
- WAIT_CMD: 0x43 ('C') -> RUN; 0x53 ('S') -> STEP_WAIT. All other bytes are ignored.
- RUN: CPU_EN=1 every cycle. When HALT_WB=1, CPU_EN drops the next cycle, the halted flag is set, and the block goes to DUMP.
- STEP_WAIT: 0x4E ('N') -> STEP. STEP: CPU_EN=1 for exactly one cycle; HALT_WB is sampled in that cycle to set the halted flag; then DUMP.
- DUMP: sends the optional cycle count (see Configuration), then DUMP_SEL = 0..DUMP_WORDS-1, 4 bytes each, MSB first. At the end it goes to DONE if the halted flag is set, else STEP_WAIT.
- DONE: 0x52 ('R') -> CPU_RESET=1 for one cycle; clears cycle counter, halted flag and PM_ADDR; goes to IDLE.
- Cycle counter: 32 bits, increments on every cycle with CPU_EN=1, wraps at 2^32.

## Timing
- Reset values: TX_VALID=0, TX_DATA=0, PM_WE=0, PM_ADDR=0, PM_WDATA=0, CPU_EN=0, CPU_RESET=0, DUMP_SEL=0; state=IDLE; counters cleared.
- TX handshake: TX_DATA is held stable while TX_VALID=1 until TX_READY=1. The next byte may be presented the following cycle; there is no bubble required.
- Load latency: PM_WE is registered and asserts the cycle after the 4th byte is accepted.
- RX_VALID during DUMP, RUN or STEP: the byte is dropped.
- HALT_WB in the first RUN cycle is honoured.
- Reset asserted mid-state: immediate return to IDLE, outputs forced to reset values, and any partial word is discarded.

## Configuration
- DBG_CYCLE_COUNT_EN defined: the dump is prefixed with the 4-byte cycle count, MSB first (4 + 4*DUMP_WORDS bytes total).
- DBG_CYCLE_COUNT_EN undefined: the counter logic is removed and the dump is exactly 4*DUMP_WORDS bytes.

## Test plan
- Load and halt detection: send 'L', 0x20,0x01,0x00,0x05, then FF,FF,FF,FF -> PM_WE pulses at addr 0 with 0x20010005 and at addr 1 with 0xFFFFFFFF; state becomes WAIT_CMD.
- Load overflow: with PM_DEPTH=4, send 'L' and 5 non-halt words -> exactly 4 writes (addr 0..3); the 5th word's bytes are ignored.
- Continuous run: 'C', with the model asserting HALT_WB on cycle 10 -> CPU_EN high for 10 cycles; a dump follows with count 0x0000000A (macro on); state becomes DONE.
- Step mode: 'S', 'N', 'N' -> each 'N' gives exactly one CPU_EN cycle followed by a full dump; counts are 1 then 2.
- TX backpressure: TX_READY toggled 1-0-0-1 during a dump -> no byte is lost or duplicated; the byte count equals 4 + 4*DUMP_WORDS.
- Async reset mid-DUMP -> all outputs return to reset values without waiting for a clock edge; a subsequent 'L' load works normally.

Source files
------------

// File: rtl/mips_debug_ctrl_if.sv
// Host-link, program-memory, pipeline-control and debug-dump signals of mips_debug_ctrl.
// master = the debug controller; slave = the UART FIFOs / TP4 top-level side.
interface mips_debug_ctrl_if #(
    parameter int PM_DEPTH   = 64,
    parameter int DUMP_WORDS = 97
);
    localparam int PM_AW = $clog2(PM_DEPTH);
    localparam int DS_W  = $clog2(DUMP_WORDS);

    logic             RX_VALID;
    logic [7:0]       RX_DATA;
    logic             TX_READY;
    logic             TX_VALID;
    logic [7:0]       TX_DATA;
    logic             PM_WE;
    logic [PM_AW-1:0] PM_ADDR;
    logic [31:0]      PM_WDATA;
    logic             CPU_EN;
    logic             CPU_RESET;
    logic             HALT_WB;
    logic [DS_W-1:0]  DUMP_SEL;
    logic [31:0]      DUMP_DATA;

    modport master (
        input  RX_VALID, RX_DATA, TX_READY, HALT_WB, DUMP_DATA,
        output TX_VALID, TX_DATA, PM_WE, PM_ADDR, PM_WDATA, CPU_EN, CPU_RESET, DUMP_SEL
    );

    modport slave (
        output RX_VALID, RX_DATA, TX_READY, HALT_WB, DUMP_DATA,
        input  TX_VALID, TX_DATA, PM_WE, PM_ADDR, PM_WDATA, CPU_EN, CPU_RESET, DUMP_SEL
    );
endinterface

// File: rtl/mips_debug_ctrl.sv
// TP4 debug/load controller: host bytes -> program memory, run/step control, state dump.
// Define DBG_CYCLE_COUNT_EN to prefix every dump with the 32-bit CPU_EN cycle count.
module mips_debug_ctrl #(
    parameter int          PM_DEPTH   = 64,
    parameter int          DUMP_WORDS = 97,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic              CLK,
    input  logic              RESET,
    mips_debug_ctrl_if.master bus
);
    localparam int PM_AW = $clog2(PM_DEPTH);
    localparam int DS_W  = $clog2(DUMP_WORDS);
`ifdef DBG_CYCLE_COUNT_EN
    localparam int CNT_WORDS = 1;
`else
    localparam int CNT_WORDS = 0;
`endif
    localparam int              WC_W        = $clog2(DUMP_WORDS + CNT_WORDS + 1);
    localparam logic [WC_W-1:0] TOTAL_WORDS = WC_W'(DUMP_WORDS + CNT_WORDS);

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_CONT  = 8'h43;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_NEXT  = 8'h4E;
    localparam logic [7:0] CMD_RESET = 8'h52;

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_CMD, RUN, STEP_WAIT, STEP, DUMP, DONE
    } state_t;

    state_t           state;
    logic [1:0]       byte_cnt;
    logic [23:0]      asm_word;
    logic [23:0]      shreg;
    logic [WC_W-1:0]  word_cnt;
    logic             halted;
    logic             pm_we;
    logic [PM_AW-1:0] pm_addr;
    logic [31:0]      pm_wdata;
    logic             cpu_en;
    logic             cpu_reset;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic [DS_W-1:0]  dump_sel;

    logic [31:0] rx_word;
    logic [31:0] next_word;
    logic        data_word;
    logic        tx_free;

    assign rx_word = {asm_word, bus.RX_DATA};
    assign tx_free = !tx_valid || bus.TX_READY;

`ifdef DBG_CYCLE_COUNT_EN
    logic [31:0] cyc_cnt;
    assign data_word = (word_cnt != '0);
    assign next_word = data_word ? bus.DUMP_DATA : cyc_cnt;
`else
    assign data_word = 1'b1;
    assign next_word = bus.DUMP_DATA;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            asm_word  <= '0;
            shreg     <= '0;
            word_cnt  <= '0;
            halted    <= 1'b0;
            pm_we     <= 1'b0;
            pm_addr   <= '0;
            pm_wdata  <= '0;
            cpu_en    <= 1'b0;
            cpu_reset <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            dump_sel  <= '0;
`ifdef DBG_CYCLE_COUNT_EN
            cyc_cnt   <= '0;
`endif
        end else begin
            pm_we     <= 1'b0;
            cpu_reset <= 1'b0;
            // Address advances after the write strobe so PM_ADDR is valid during PM_WE.
            if (pm_we) pm_addr <= pm_addr + PM_AW'(1);
`ifdef DBG_CYCLE_COUNT_EN
            if (cpu_en) cyc_cnt <= cyc_cnt + 32'd1;
`endif
            case (state)
                IDLE: begin
                    if (bus.RX_VALID && bus.RX_DATA == CMD_LOAD) begin
                        state    <= LOAD;
                        pm_addr  <= '0;
                        byte_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (bus.RX_VALID) begin
                        asm_word <= rx_word[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            pm_we    <= 1'b1;
                            pm_wdata <= rx_word;
                            if (rx_word == HALT_WORD || pm_addr == PM_AW'(PM_DEPTH - 1))
                                state <= WAIT_CMD;
                        end
                    end
                end
                WAIT_CMD: begin
                    if (bus.RX_VALID && bus.RX_DATA == CMD_CONT) begin
                        state  <= RUN;
                        cpu_en <= 1'b1;
                    end else if (bus.RX_VALID && bus.RX_DATA == CMD_STEP) begin
                        state <= STEP_WAIT;
                    end
                end
                RUN: begin
                    if (bus.HALT_WB) begin
                        cpu_en   <= 1'b0;
                        halted   <= 1'b1;
                        state    <= DUMP;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                        dump_sel <= '0;
                    end
                end
                STEP_WAIT: begin
                    if (bus.RX_VALID && bus.RX_DATA == CMD_NEXT) begin
                        state  <= STEP;
                        cpu_en <= 1'b1;
                    end
                end
                STEP: begin
                    cpu_en   <= 1'b0;
                    if (bus.HALT_WB) halted <= 1'b1;
                    state    <= DUMP;
                    word_cnt <= '0;
                    byte_cnt <= '0;
                    dump_sel <= '0;
                end
                DUMP: begin
                    if (tx_free) begin
                        if (word_cnt == TOTAL_WORDS) begin
                            tx_valid <= 1'b0;
                            dump_sel <= '0;
                            state    <= halted ? DONE : STEP_WAIT;
                        end else begin
                            tx_valid <= 1'b1;
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd0) begin
                                tx_data <= next_word[31:24];
                                shreg   <= next_word[23:0];
                            end else begin
                                tx_data <= shreg[23:16];
                                shreg   <= {shreg[15:0], 8'h00};
                            end
                            // Select the next debug word a cycle early so DUMP_DATA has settled.
                            if (byte_cnt == 2'd3) begin
                                word_cnt <= word_cnt + WC_W'(1);
                                if (data_word && dump_sel != DS_W'(DUMP_WORDS - 1))
                                    dump_sel <= dump_sel + DS_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    if (bus.RX_VALID && bus.RX_DATA == CMD_RESET) begin
                        cpu_reset <= 1'b1;
                        halted    <= 1'b0;
                        pm_addr   <= '0;
`ifdef DBG_CYCLE_COUNT_EN
                        cyc_cnt   <= '0;
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.TX_VALID  = tx_valid;
    assign bus.TX_DATA   = tx_data;
    assign bus.PM_WE     = pm_we;
    assign bus.PM_ADDR   = pm_addr;
    assign bus.PM_WDATA  = pm_wdata;
    assign bus.CPU_EN    = cpu_en;
    assign bus.CPU_RESET = cpu_reset;
    assign bus.DUMP_SEL  = dump_sel;
endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Directed-sequence bench for mips_debug_ctrl with random data, random backpressure and a
// behavioural model of program loading, CPU_EN cycle counts and dump byte streams.
module tb_mips_debug_ctrl;
    localparam int          PM_DEPTH   = 4;
    localparam int          DUMP_WORDS = 97;
    localparam logic [31:0] HALT       = 32'hFFFF_FFFF;
`ifdef DBG_CYCLE_COUNT_EN
    localparam int CNT_BYTES = 4;
`else
    localparam int CNT_BYTES = 0;
`endif
    localparam int DUMP_BYTES = CNT_BYTES + 4 * DUMP_WORDS;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    mips_debug_ctrl_if #(.PM_DEPTH(PM_DEPTH), .DUMP_WORDS(DUMP_WORDS)) bus ();

    mips_debug_ctrl #(
        .PM_DEPTH  (PM_DEPTH),
        .DUMP_WORDS(DUMP_WORDS),
        .HALT_WORD (HALT)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    int tests    = 0;
    int failures = 0;

    // Pipeline stand-in: debug words, and HALT_WB raised during a chosen CPU_EN cycle.
    logic [31:0] dbg_mem [DUMP_WORDS];
    int unsigned en_cnt      = 0;
    int unsigned halt_target = 0;
    bit          halt_arm    = 1'b0;

    assign bus.DUMP_DATA = (int'(bus.DUMP_SEL) < DUMP_WORDS) ? dbg_mem[bus.DUMP_SEL] : 32'hDEAD_BEEF;
    assign bus.HALT_WB   = halt_arm && bus.CPU_EN && (en_cnt + 1 == halt_target);

    always @(posedge CLK) if (bus.CPU_EN) en_cnt <= en_cnt + 1;

    logic [7:0]  tx_q [$];
    int unsigned pm_writes = 0;
    int unsigned hold_err  = 0;
    logic        hold_pend = 1'b0;
    logic [7:0]  hold_data = 8'h00;

    always @(negedge CLK) begin
        if (bus.TX_VALID && bus.TX_READY) tx_q.push_back(bus.TX_DATA);
        if (hold_pend && !RESET && !(bus.TX_VALID && bus.TX_DATA == hold_data)) hold_err++;
        hold_pend = bus.TX_VALID && !bus.TX_READY && !RESET;
        hold_data = bus.TX_DATA;
        if (bus.PM_WE) pm_writes++;
    end

`ifdef DBG_CYCLE_COUNT_EN
    logic [31:0] model_cyc = '0;
`endif
    task automatic model_count(input bit clear, input int unsigned n);
`ifdef DBG_CYCLE_COUNT_EN
        if (clear) model_cyc = '0;
        model_cyc = model_cyc + n;
`endif
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = b;
        tick();
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'($urandom);
    endtask

    // Random instruction that is neither the halt marker nor contains a WAIT_CMD command byte.
    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        for (int b = 0; b < 4; b++) begin
            logic [7:0] x = 8'($urandom);
            if (x == 8'h43 || x == 8'h53) x = 8'h00;
            w[31-8*b -: 8] = x;
        end
        if (w == HALT) w = 32'h0;
        return w;
    endfunction

    task automatic refresh_mem();
        for (int i = 0; i < DUMP_WORDS; i++) dbg_mem[i] = $urandom;
    endtask

    logic [31:0] prog [$];

    task automatic load_prog();
        int unsigned nexp = prog.size();
        int unsigned w0   = pm_writes;
        for (int i = 0; i < prog.size(); i++)
            if (prog[i] == HALT && nexp == prog.size()) nexp = i + 1;
        if (nexp > PM_DEPTH) nexp = PM_DEPTH;
        send(8'h4C);
        for (int i = 0; i < prog.size(); i++) begin
            logic [31:0] w = prog[i];
            for (int b = 0; b < 4; b++) begin
                send(w[31-8*b -: 8]);
                if (b < 3 && $urandom_range(0, 2) == 0) tick();
            end
            if (i < nexp) begin
                check("pm_we", 32'(bus.PM_WE), 32'd1);
                check("pm_addr", 32'(bus.PM_ADDR), 32'(i));
                check("pm_wdata", bus.PM_WDATA, w);
            end else begin
                check("pm_we_ignored", 32'(bus.PM_WE), 32'd0);
            end
        end
        tick();
        check("pm_write_count", pm_writes - w0, nexp);
    endtask

    task automatic wait_dump(input string tag);
        int         q0   = tx_q.size();
        int         cyc  = 0;
        int         nv   = 0;
        int         bad  = -1;
        bit         done = 1'b0;
        logic [3:0] pat  = 4'b1001;
        logic [7:0] cmds [5] = '{8'h52, 8'h4E, 8'h53, 8'h43, 8'h4C};
        logic [7:0] exp_q [$];
`ifdef DBG_CYCLE_COUNT_EN
        for (int b = 0; b < 4; b++) exp_q.push_back(model_cyc[31-8*b -: 8]);
`endif
        for (int i = 0; i < DUMP_WORDS; i++)
            for (int b = 0; b < 4; b++) exp_q.push_back(dbg_mem[i][31-8*b -: 8]);
        while (!done && cyc < 4000) begin
            if (bus.TX_VALID && nv < 4) begin
                bus.TX_READY = pat[3-nv];
                nv++;
            end else begin
                bus.TX_READY = ($urandom_range(0, 3) != 0);
            end
            bus.RX_VALID = ($urandom_range(0, 7) == 0);
            bus.RX_DATA  = cmds[$urandom_range(0, 4)];
            tick();
            cyc++;
            done = (tx_q.size() - q0 >= DUMP_BYTES) && !bus.TX_VALID && !bus.CPU_EN;
        end
        bus.RX_VALID = 1'b0;
        bus.TX_READY = 1'b1;
        check({tag, "_timeout"}, 32'(done), 32'd1);
        check({tag, "_bytes"}, 32'(tx_q.size() - q0), 32'(DUMP_BYTES));
        for (int i = 0; i < DUMP_BYTES && q0 + i < tx_q.size(); i++)
            if (bad < 0 && tx_q[q0+i] !== exp_q[i]) bad = i;
        check({tag, "_first_bad_byte_idx"}, 32'(bad), 32'hFFFF_FFFF);
    endtask

    task automatic run_cont(input int unsigned n);
        int unsigned base = en_cnt;
        refresh_mem();
        halt_target = en_cnt + n;
        halt_arm    = 1'b1;
        send(8'h43);
        check("run_en_start", 32'(bus.CPU_EN), 32'd1);
        model_count(1'b0, n);
        wait_dump("run_dump");
        check("run_en_cycles", en_cnt - base, n);
        halt_arm = 1'b0;
    endtask

    task automatic step_once(input bit halt_now);
        int unsigned base = en_cnt;
        refresh_mem();
        halt_target = en_cnt + 1;
        halt_arm    = halt_now;
        send(8'h4E);
        check("step_en", 32'(bus.CPU_EN), 32'd1);
        model_count(1'b0, 1);
        wait_dump("step_dump");
        check("step_en_cycles", en_cnt - base, 32'd1);
        halt_arm = 1'b0;
    endtask

    task automatic host_reset();
        send(8'h52);
        check("cpu_reset_pulse", 32'(bus.CPU_RESET), 32'd1);
        check("pm_addr_cleared", 32'(bus.PM_ADDR), 32'd0);
        tick();
        check("cpu_reset_single", 32'(bus.CPU_RESET), 32'd0);
        model_count(1'b1, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, 32'(bus.TX_VALID), 32'd0);
        check({tag, "_tx_data"}, 32'(bus.TX_DATA), 32'd0);
        check({tag, "_pm_we"}, 32'(bus.PM_WE), 32'd0);
        check({tag, "_pm_addr"}, 32'(bus.PM_ADDR), 32'd0);
        check({tag, "_pm_wdata"}, bus.PM_WDATA, 32'd0);
        check({tag, "_cpu_en"}, 32'(bus.CPU_EN), 32'd0);
        check({tag, "_cpu_reset"}, 32'(bus.CPU_RESET), 32'd0);
        check({tag, "_dump_sel"}, 32'(bus.DUMP_SEL), 32'd0);
    endtask

    initial begin
        int unsigned e0;
        int          q0;
        int          cyc;
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'h00;
        bus.TX_READY = 1'b1;
        refresh_mem();

        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RESET = 1'b0;
        tick();

        // Non-'L' bytes in IDLE are ignored
        send(8'h43); send(8'h53); send(8'h52); send(8'h4E); send(8'($urandom_range(0, 8'h4B)));
        check("idle_no_write", pm_writes, 32'd0);
        check("idle_no_run", en_cnt, 32'd0);

        // Load up to and including the halt marker; trailing word is ignored
        prog.delete();
        prog.push_back(rnd_word());
        prog.push_back(32'h2001_0005);
        prog.push_back(HALT);
        prog.push_back(rnd_word());
        load_prog();

        run_cont(10);
        send(8'h4C);
        check("done_ignores_other", 32'(bus.CPU_RESET), 32'd0);
        host_reset();

        // Overflow: only PM_DEPTH words are written
        prog.delete();
        for (int i = 0; i < 5; i++) prog.push_back(rnd_word());
        load_prog();

        send(8'h53);
        step_once(1'b0);
        step_once(1'b0);
        step_once(1'b1);
        e0 = en_cnt;
        send(8'h4E);
        tick();
        check("done_ignores_step", en_cnt - e0, 32'd0);
        host_reset();

        // Halt in the very first RUN cycle
        prog.delete();
        prog.push_back(rnd_word());
        prog.push_back(HALT);
        load_prog();
        run_cont(1);
        host_reset();

        // Asynchronous reset in the middle of a dump
        prog.delete();
        prog.push_back(HALT);
        load_prog();
        halt_target = en_cnt + 3;
        halt_arm    = 1'b1;
        send(8'h43);
        q0  = tx_q.size();
        cyc = 0;
        while (tx_q.size() - q0 < 10 && cyc < 500) begin
            tick();
            cyc++;
        end
        check("mid_dump_reached", 32'(tx_q.size() - q0 >= 10), 32'd1);
        #2 RESET = 1'b1;
        #1 check_reset_outputs("async_reset");
        halt_arm = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b0;
        model_count(1'b1, 0);
        tick();

        prog.delete();
        prog.push_back(rnd_word());
        prog.push_back(HALT);
        load_prog();
        run_cont($urandom_range(2, 12));

        check("tx_hold_violations", hold_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
